// File: rtl/pwm_duty_meter.sv
// rtl/pwm_duty_meter.sv - per-channel PWM high-time / period meter with stuck detection
module pwm_duty_meter #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [CHANNELS-1:0]       pwm_in,
  output logic [CHANNELS*CNT_W-1:0] high_cnt,
  output logic [CHANNELS*CNT_W-1:0] period_cnt,
  output logic [CHANNELS-1:0]       meas_valid,
  output logic [CHANNELS-1:0]       stuck
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CHANNELS-1:0] s1;
  logic [CHANNELS-1:0] s2;
  logic [CHANNELS-1:0] s3;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] rise;

  state_t           state      [CHANNELS];
  logic [CNT_W-1:0] run_period [CHANNELS];
  logic [CNT_W-1:0] run_high   [CHANNELS];

  // s2 is the first metastability-safe copy; s3 only exists to find the edge
  assign level = s2;
  assign rise  = s2 & ~s3;

  // Three-flop synchroniser on every PWM input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Per-channel measurement FSM: rise-to-rise period, high time, timeout to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_cnt   <= '0;
      period_cnt <= '0;
      meas_valid <= '0;
      stuck      <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        state[i]      <= IDLE;
        run_period[i] <= '0;
        run_high[i]   <= '0;
      end
    end else begin
      meas_valid <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        if (!enable) begin
          // Disabled: drop any partial period, keep the last results on the outputs
          state[i]      <= IDLE;
          run_period[i] <= '0;
          run_high[i]   <= '0;
        end else begin
          case (state[i])
            IDLE: begin
              if (rise[i]) begin
                state[i]      <= MEASURE;
                run_period[i] <= CNT_ONE;
                run_high[i]   <= CNT_ONE;
              end else begin
                run_period[i] <= '0;
                run_high[i]   <= '0;
              end
            end
            MEASURE: begin
              if (rise[i]) begin
                // A rise wins over a coincident timeout: it is a real period
                high_cnt[i*CNT_W +: CNT_W]   <= run_high[i];
                period_cnt[i*CNT_W +: CNT_W] <= run_period[i];
                meas_valid[i]                <= 1'b1;
                stuck[i]                     <= 1'b0;
                run_period[i]                <= CNT_ONE;
                run_high[i]                  <= CNT_ONE;
              end else if (run_period[i] == CNT_MAX) begin
                // No edge within the counter range: report saturated values
                period_cnt[i*CNT_W +: CNT_W] <= CNT_MAX;
                high_cnt[i*CNT_W +: CNT_W]   <= level[i] ? CNT_MAX : '0;
                meas_valid[i]                <= 1'b1;
                stuck[i]                     <= 1'b1;
                state[i]                     <= IDLE;
                run_period[i]                <= '0;
                run_high[i]                  <= '0;
              end else begin
                run_period[i] <= run_period[i] + CNT_ONE;
                run_high[i]   <= run_high[i] + CNT_W'(level[i]);
              end
            end
            default: begin
              state[i]      <= IDLE;
              run_period[i] <= '0;
              run_high[i]   <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// tb/tb_pwm_duty_meter.sv - directed self-checking bench for pwm_duty_meter
module tb_pwm_duty_meter;
  localparam int CH = 4;
  localparam int W  = 8;

  logic            clk    = 1'b0;
  logic            rst_n  = 1'b0;
  logic            enable = 1'b0;
  logic [CH-1:0]   pwm_in = '0;
  logic [CH*W-1:0] high_cnt;
  logic [CH*W-1:0] period_cnt;
  logic [CH-1:0]   meas_valid;
  logic [CH-1:0]   stuck;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Generator configuration (written by the stimulus) and state (written by the generator)
  int   g_per   [CH] = '{0, 0, 0, 0};
  int   g_high  [CH] = '{0, 0, 0, 0};
  int   g_epoch [CH] = '{0, 0, 0, 0};
  logic g_hold  [CH] = '{1'b0, 1'b0, 1'b0, 1'b0};
  int   g_cnt   [CH] = '{0, 0, 0, 0};
  int   g_seen  [CH] = '{0, 0, 0, 0};
  int   rise_cnt[CH] = '{0, 0, 0, 0};
  int   rise_cyc[CH] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  pwm_duty_meter #(.CHANNELS(CH), .CNT_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .pwm_in     (pwm_in),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .meas_valid (meas_valid),
    .stuck      (stuck)
  );

  always @(posedge clk) cyc = cyc + 1;

  // PWM waveform source: period/high per channel, or a held level when period is 0
  always @(negedge clk) begin : gen_blk
    logic nv;
    for (int c = 0; c < CH; c++) begin
      if (g_seen[c] != g_epoch[c]) begin
        g_seen[c] = g_epoch[c];
        g_cnt[c]  = 0;
      end
      if (g_per[c] == 0) begin
        nv = g_hold[c];
      end else begin
        nv = (g_cnt[c] < g_high[c]);
        g_cnt[c] = (g_cnt[c] + 1 >= g_per[c]) ? 0 : g_cnt[c] + 1;
      end
      if (nv && !pwm_in[c]) begin
        rise_cnt[c] = rise_cnt[c] + 1;
        rise_cyc[c] = cyc;
      end
      pwm_in[c] = nv;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_gen(input int c, input int per, input int hi, input logic hold);
    g_per[c]   = per;
    g_high[c]  = hi;
    g_hold[c]  = hold;
    g_epoch[c] = g_epoch[c] + 1;
  endtask

  task automatic sync;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input int c, input int budget, input string tag, output bit found);
    found = 1'b0;
    for (int n = 0; n < budget && !found; n++) begin
      @(negedge clk);
      if (meas_valid[c]) found = 1'b1;
    end
    if (!found) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  function automatic logic [31:0] hc(input int c);
    return 32'(high_cnt[c*W +: W]);
  endfunction

  function automatic logic [31:0] pc(input int c);
    return 32'(period_cnt[c*W +: W]);
  endfunction

  initial begin : stim
    bit          f;
    int          t1;
    int          base;
    logic [CH-1:0] acc;
    int          exp_high[CH] = '{20, 40, 60, 80};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_high", 32'(high_cnt), 32'd0);
    check("rst_period", 32'(period_cnt), 32'd0);
    check("rst_valid", 32'(meas_valid), 32'd0);
    check("rst_stuck", 32'(stuck), 32'd0);
    sync;
    rst_n  = 1'b1;
    enable = 1'b1;

    // No edge ever seen: IDLE never times out
    repeat (300) @(negedge clk);
    check("idle_stuck", 32'(stuck), 32'd0);
    check("idle_period", 32'(period_cnt), 32'd0);

    // Generator-shaped waveforms: period 101, highs 20/40/60/80
    sync;
    for (int c = 0; c < CH; c++) set_gen(c, 101, exp_high[c], 1'b0);
    wait_valid(0, 300, "gen", f);
    if (f) begin
      for (int c = 0; c < CH; c++) begin
        check($sformatf("gen_high%0d", c), hc(c), 32'(exp_high[c]));
        check($sformatf("gen_period%0d", c), pc(c), 32'd101);
      end
      check("gen_valid_all", 32'(meas_valid), 32'hF);
      check("gen_stuck", 32'(stuck), 32'd0);
      check("gen_latency", 32'(cyc - (rise_cyc[0] + 1)), 32'd2);
      t1 = cyc;
      @(negedge clk);
      check("gen_pulse_width", 32'(meas_valid), 32'd0);
      wait_valid(0, 150, "gen2", f);
      if (f) check("gen_interval", 32'(cyc - t1), 32'd101);
    end
    sync;
    for (int c = 0; c < CH; c++) set_gen(c, 0, 0, 1'b0);
    enable = 1'b0;
    repeat (3) sync;
    enable = 1'b1;

    // Channel 0 held low after one rise: timeout with high 0, then recovery
    sync;
    set_gen(0, 0, 0, 1'b1);
    repeat (3) sync;
    set_gen(0, 0, 0, 1'b0);
    wait_valid(0, 400, "low_to", f);
    if (f) begin
      check("low_to_period", pc(0), 32'd255);
      check("low_to_high", hc(0), 32'd0);
      check("low_to_stuck", 32'(stuck[0]), 32'd1);
    end
    sync;
    set_gen(0, 10, 3, 1'b0);
    wait_valid(0, 100, "recover", f);
    if (f) begin
      check("recover_period", pc(0), 32'd10);
      check("recover_high", hc(0), 32'd3);
      check("recover_stuck", 32'(stuck[0]), 32'd0);
    end

    // Channel 1 held high after a rise: timeout with high all-ones
    sync;
    set_gen(0, 0, 0, 1'b0);
    set_gen(1, 0, 0, 1'b1);
    wait_valid(1, 400, "high_to", f);
    if (f) begin
      check("high_to_high", hc(1), 32'd255);
      check("high_to_period", pc(1), 32'd255);
      check("high_to_stuck", 32'(stuck[1]), 32'd1);
    end
    sync;
    set_gen(1, 0, 0, 1'b0);

    // 1-cycle pulses every 5 cycles on channel 2, with latency check
    sync;
    set_gen(2, 5, 1, 1'b0);
    wait_valid(2, 50, "pulse", f);
    if (f) begin
      check("pulse_high", hc(2), 32'd1);
      check("pulse_period", pc(2), 32'd5);
      check("pulse_latency", 32'(cyc - (rise_cyc[2] + 1)), 32'd2);
      t1 = cyc;
      wait_valid(2, 20, "pulse2", f);
      if (f) begin
        check("pulse_interval", 32'(cyc - t1), 32'd5);
        check("pulse2_high", hc(2), 32'd1);
      end
    end

    // Enable dropped 30 cycles mid-period on channel 3
    sync;
    set_gen(2, 0, 0, 1'b0);
    set_gen(3, 20, 7, 1'b0);
    wait_valid(3, 100, "en_first", f);
    if (f) begin
      check("en_first_high", hc(3), 32'd7);
      check("en_first_period", pc(3), 32'd20);
    end
    repeat (15) @(negedge clk);
    enable = 1'b0;
    acc = '0;
    repeat (30) begin
      @(negedge clk);
      acc = acc | meas_valid;
    end
    check("en_off_valid", 32'(acc), 32'd0);
    check("en_off_high_hold", hc(3), 32'd7);
    check("en_off_period_hold", pc(3), 32'd20);
    enable = 1'b1;
    base = rise_cnt[3];
    wait_valid(3, 100, "en_back", f);
    if (f) begin
      check("en_back_rises", 32'(rise_cnt[3] - base), 32'd2);
      check("en_back_high", hc(3), 32'd7);
      check("en_back_period", pc(3), 32'd20);
    end

    // Asynchronous reset mid-measurement on channel 0
    sync;
    set_gen(3, 0, 0, 1'b0);
    set_gen(0, 12, 4, 1'b0);
    wait_valid(0, 100, "pre_rst", f);
    if (f) begin
      check("pre_rst_high", hc(0), 32'd4);
      check("pre_rst_period", pc(0), 32'd12);
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_high", 32'(high_cnt), 32'd0);
    check("arst_period", 32'(period_cnt), 32'd0);
    check("arst_valid", 32'(meas_valid), 32'd0);
    check("arst_stuck", 32'(stuck), 32'd0);
    set_gen(0, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) sync;
    base = rise_cnt[0];
    set_gen(0, 12, 4, 1'b0);
    wait_valid(0, 100, "post_rst", f);
    if (f) begin
      check("post_rst_rises", 32'(rise_cnt[0] - base), 32'd2);
      check("post_rst_high", hc(0), 32'd4);
      check("post_rst_period", pc(0), 32'd12);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
